clic_timer: RTL and testbench
=============================

# clic_timer

Periodic/one-shot timer peripheral that raises an interrupt request into the N-CLIC of `top_n_clic`; it is the interrupt source directly upstream of the CLIC. It is configured through the core's CSR access path. It holds a level-style pending request until the CLIC acknowledges vector entry, and flags an overrun when it expires again while a request is still pending.

## Interface
- `CounterWidth`, 16: width of the tick counter and compare field (max 16).
- `PrescaleWidth`, 4: width of the prescale exponent field.
- `CsrAddr`, 12'h400: address of the config CSR; `CsrAddr+1` is the read-only count CSR.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; every register clears immediately while `reset`=0.
- `csr_enable` in 1: CSR access strobe, one cycle per access.
- `csr_addr` in 12: CSR address.
- `csr_op` in 2: 01 write, 10 set bits, 11 clear bits, 00 read-only.
- `csr_wdata` in 32: write/set/clear operand.
- `csr_rdata` out 32: combinational read of the addressed CSR; 0 when the address does not match.
- `irq_pend` out 1: pending interrupt request to the CLIC.
- `irq_ack` in 1: CLIC entry acknowledge, one cycle; clears `irq_pend`.
- `irq_overrun` out 1: sticky overrun flag, mirrors config bit 22.

## Operation
- Config CSR layout:
  - [CounterWidth-1:0] `compare`.
  - [16+PrescaleWidth-1:16] `prescale` P.
  - [20] `en`.
  - [21] `periodic`.
  - [22] `overrun` (read-only).
  - Other bits read 0.
- Count CSR reads `count`, zero-extended. Writes to it are ignored.
- Any config write/set/clear (op≠00):
  - updates `compare`/`prescale`/`en`/`periodic`;
  - clears `count` and `pcnt` (prescaler counter);
  - takes effect at that edge (E0).
  - Writing `en`=0 also clears `overrun`.
- States:
  - IDLE: `en`=0, counters frozen at 0.
  - RUN: `en`=1.
  - HOLD: one-shot expired; `en` already cleared, counters frozen.
- Transitions:
  - IDLE→RUN on a config op leaving `en`=1.
  - RUN→IDLE on a config op leaving `en`=0.
  - RUN→HOLD on one-shot expiry.
  - HOLD→RUN/IDLE on the next config op, per resulting `en`.
- Prescaler (RUN only):
  - `pcnt` increments every cycle.
  - Tick asserted when `pcnt[P-1:0]` is all ones; always asserted when P=0.
  - `pcnt` wraps modulo 2^P.
- On a tick:
  - If `count`==`compare`: expiry, `count`←0.
  - Otherwise `count`←`count`+1.
- Expiry:
  - `irq_pend`←1.
  - If `periodic`=0: `en`←0 and state becomes HOLD.
- Overrun: set when an expiry occurs while `irq_pend`=1 and `irq_ack`=0 in that cycle.
- Simultaneous expiry and `irq_ack`: `irq_pend` stays 1, no overrun.
- `irq_ack` with no expiry clears `irq_pend`. `irq_ack` while `irq_pend`=0 has no effect.
- CSR op and expiry in the same cycle: the CSR op wins. Counters reset, no expiry is recorded, and `irq_pend` is unchanged (`irq_ack` still applies).
- `compare`=0 means expiry on every tick.
- `compare` is never adjusted relative to `count`. A written value below the running `count` cannot occur because a write clears `count`.

## Timing
- Reset values:
  - `irq_pend`=0, `irq_overrun`=0.
  - Config=0, `count`=0, `pcnt`=0, state IDLE.
  - `csr_rdata` reads 0 for both addresses.
- First expiry edge: E0+(compare+1)·2^P. `irq_pend` is visible in the cycle after that edge.
- Period in periodic mode: (compare+1)·2^P cycles, exact with no drift, independent of ack timing.
- `irq_ack` at edge Ea: `irq_pend`=0 from Ea.
- `csr_rdata` reflects register state before the current edge, so a read in the same cycle as a write returns the old value.
- Reset asserted mid-count: all state clears asynchronously. After release, the block stays IDLE until configured.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, then release -> `irq_pend`=0, `irq_overrun`=0, reads of 12'h400 and 12'h401 return 0.
- Periodic, P=0: write 0x0030_0003 -> `irq_pend` rises at E0+4. Ack at E0+6 -> low. Rises again at E0+8, count CSR reads 0 at E0+8.
- Prescaled: P=2, compare=1, write 0x0032_0001 -> `irq_pend` rises at E0+8, next expiry at E0+16. Count CSR reads 1 between E0+4 and E0+8.
- One-shot: write 0x0010_0002 -> `irq_pend` at E0+3. Config then reads 0x0000_0002 with `en`=0, and no further expiry within 50 cycles after ack.
- Overrun and simultaneity:
  - periodic compare=1, no ack -> `irq_overrun`=1 at E0+4;
  - clear-op on bit 20 -> `overrun` reads 0;
  - ack coincident with an expiry edge -> `irq_pend` stays 1, `irq_overrun` stays 0.
- Reset mid-operation: periodic compare=9, assert `reset`=0 at E0+5 between clock edges -> outputs clear immediately. No `irq_pend` for 30 cycles after release.

Source files
------------

// File: rtl/clic_timer.sv
// clic_timer: periodic/one-shot timer that raises a level-held interrupt request
// toward the CLIC. One config CSR and one read-only count CSR sit on the core's
// CSR access path. A request stays pending until the CLIC acknowledges vector
// entry. A sticky overrun flag records an expiry that lands on an unacknowledged
// request.

module clic_timer #(
    parameter int unsigned CounterWidth  = 16,
    parameter int unsigned PrescaleWidth = 4,
    parameter logic [11:0] CsrAddr       = 12'h400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        irq_pend,
    input  logic        irq_ack,
    output logic        irq_overrun
);

    // The prescaler counter must hold the largest exponent's worth of bits.
    localparam int unsigned PcntWidth   = (1 << PrescaleWidth) - 1;
    localparam logic [11:0] CountAddr   = CsrAddr + 12'd1;

    localparam int unsigned PrescaleLsb = 16;
    localparam int unsigned EnBit       = 20;
    localparam int unsigned PeriodicBit = 21;
    localparam int unsigned OverrunBit  = 22;

    localparam logic [1:0] OpRead  = 2'b00;
    localparam logic [1:0] OpWrite = 2'b01;
    localparam logic [1:0] OpSet   = 2'b10;
    localparam logic [1:0] OpClear = 2'b11;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    // Architectural state
    logic [CounterWidth-1:0]  r_compare;
    logic [PrescaleWidth-1:0] r_prescale;
    logic                     r_en;
    logic                     r_periodic;
    logic                     r_overrun;
    logic                     r_pend;
    logic [CounterWidth-1:0]  r_count;
    logic [PcntWidth-1:0]     r_pcnt;
    logic [1:0]               r_state;

    // Next-state values
    logic [CounterWidth-1:0]  w_compare_nxt;
    logic [PrescaleWidth-1:0] w_prescale_nxt;
    logic                     w_en_nxt;
    logic                     w_periodic_nxt;
    logic                     w_overrun_nxt;
    logic                     w_pend_nxt;
    logic [CounterWidth-1:0]  w_count_nxt;
    logic [PcntWidth-1:0]     w_pcnt_nxt;
    logic [1:0]               w_state_nxt;

    // Decode / datapath
    logic [31:0]              w_cfg_word;
    logic [31:0]              w_cfg_new;
    logic                     w_cfg_sel;
    logic                     w_cnt_sel;
    logic                     w_cfg_op;
    logic [PcntWidth-1:0]     w_mask;
    logic                     w_tick;
    logic                     w_match;
    logic                     w_expire;

    assign w_cfg_sel = (csr_addr == CsrAddr);
    assign w_cnt_sel = (csr_addr == CountAddr);
    assign w_cfg_op  = csr_enable && w_cfg_sel && (csr_op != OpRead);

    // Assemble the config CSR image from its fields; unused bits read 0.
    always_comb begin
        w_cfg_word                                    = '0;
        w_cfg_word[CounterWidth-1:0]                  = r_compare;
        w_cfg_word[PrescaleLsb +: PrescaleWidth]      = r_prescale;
        w_cfg_word[EnBit]                             = r_en;
        w_cfg_word[PeriodicBit]                       = r_periodic;
        w_cfg_word[OverrunBit]                        = r_overrun;
    end

    // Combinational CSR read of whichever register is addressed.
    always_comb begin
        csr_rdata = '0;
        if (w_cfg_sel) begin
            csr_rdata = w_cfg_word;
        end else if (w_cnt_sel) begin
            csr_rdata[CounterWidth-1:0] = r_count;
        end
    end

    // Resulting config image for a write/set/clear access.
    always_comb begin
        case (csr_op)
            OpWrite: w_cfg_new = csr_wdata;
            OpSet:   w_cfg_new = w_cfg_word | csr_wdata;
            OpClear: w_cfg_new = w_cfg_word & ~csr_wdata;
            default: w_cfg_new = w_cfg_word;
        endcase
    end

    // Low P bits of the prescaler counter take part in the tick decode; P=0 gives
    // an empty mask so every RUN cycle ticks.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < PcntWidth; i++) begin
            w_mask[i] = (PrescaleWidth'(i) < r_prescale);
        end
    end

    assign w_tick   = (r_state == StRun) && ((r_pcnt & w_mask) == w_mask);
    assign w_match  = (r_count == r_compare);
    // A config access in the same cycle suppresses the expiry entirely.
    assign w_expire = w_tick && w_match && !w_cfg_op;

    // Next-state computation for config, counters, FSM and interrupt flags.
    always_comb begin
        w_compare_nxt  = r_compare;
        w_prescale_nxt = r_prescale;
        w_en_nxt       = r_en;
        w_periodic_nxt = r_periodic;
        w_overrun_nxt  = r_overrun;
        w_count_nxt    = r_count;
        w_pcnt_nxt     = r_pcnt;
        w_state_nxt    = r_state;

        if (w_cfg_op) begin
            w_compare_nxt  = w_cfg_new[CounterWidth-1:0];
            w_prescale_nxt = w_cfg_new[PrescaleLsb +: PrescaleWidth];
            w_en_nxt       = w_cfg_new[EnBit];
            w_periodic_nxt = w_cfg_new[PeriodicBit];
            w_count_nxt    = '0;
            w_pcnt_nxt     = '0;
            w_state_nxt    = w_cfg_new[EnBit] ? StRun : StIdle;
            // Disabling the timer is also how software clears the overrun flag.
            if (!w_cfg_new[EnBit]) begin
                w_overrun_nxt = 1'b0;
            end
        end else if (r_state == StRun) begin
            w_pcnt_nxt = (r_pcnt + PcntWidth'(1)) & w_mask;
            if (w_tick) begin
                if (w_match) begin
                    w_count_nxt = '0;
                    if (!r_periodic) begin
                        w_en_nxt    = 1'b0;
                        w_state_nxt = StHold;
                    end
                    if (r_pend && !irq_ack) begin
                        w_overrun_nxt = 1'b1;
                    end
                end else begin
                    w_count_nxt = r_count + CounterWidth'(1);
                end
            end
        end
    end

    // Pending request: expiry sets it and beats a coincident ack.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_expire) begin
            w_pend_nxt = 1'b1;
        end else if (irq_ack) begin
            w_pend_nxt = 1'b0;
        end
    end

    // State registers, cleared asynchronously while reset is low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_compare  <= '0;
            r_prescale <= '0;
            r_en       <= 1'b0;
            r_periodic <= 1'b0;
            r_overrun  <= 1'b0;
            r_pend     <= 1'b0;
            r_count    <= '0;
            r_pcnt     <= '0;
            r_state    <= StIdle;
        end else begin
            r_compare  <= w_compare_nxt;
            r_prescale <= w_prescale_nxt;
            r_en       <= w_en_nxt;
            r_periodic <= w_periodic_nxt;
            r_overrun  <= w_overrun_nxt;
            r_pend     <= w_pend_nxt;
            r_count    <= w_count_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_state    <= w_state_nxt;
        end
    end

    assign irq_pend    = r_pend;
    assign irq_overrun = r_overrun;

endmodule

// File: tb/tb_clic_timer.sv
// Directed self-checking bench for clic_timer. Stimulus is driven and outputs are
// sampled around the falling edge; cyc counts rising edges since the last CSR access.

module tb_clic_timer;

    localparam logic [11:0] CfgAddr = 12'h400;
    localparam logic [11:0] CntAddr = 12'h401;
    localparam logic [1:0]  OpWrite = 2'b01;
    localparam logic [1:0]  OpSet   = 2'b10;
    localparam logic [1:0]  OpClear = 2'b11;

    logic        clk;
    logic        reset;
    logic        csr_enable;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        irq_pend;
    logic        irq_ack;
    logic        irq_overrun;

    int errors;
    int checks;
    int cyc;

    clic_timer #(
        .CounterWidth  (16),
        .PrescaleWidth (4),
        .CsrAddr       (12'h400)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .csr_enable  (csr_enable),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .irq_pend    (irq_pend),
        .irq_ack     (irq_ack),
        .irq_overrun (irq_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic advance_to(input int n);
        while (cyc < n) step();
    endtask

    // One-cycle CSR access; the rising edge it lands on becomes cycle 0 (E0).
    task automatic csr_access(input logic [1:0] op, input logic [11:0] addr,
                              input logic [31:0] data, input logic ack,
                              output logic [31:0] rd_before);
        csr_enable = 1'b1;
        csr_op     = op;
        csr_addr   = addr;
        csr_wdata  = data;
        irq_ack    = ack;
        #1;
        rd_before = csr_rdata;
        @(posedge clk);
        @(negedge clk);
        csr_enable = 1'b0;
        csr_op     = 2'b00;
        csr_wdata  = '0;
        irq_ack    = 1'b0;
        csr_addr   = CfgAddr;
        cyc        = 0;
    endtask

    task automatic read_csr(input logic [11:0] addr, output logic [31:0] d);
        csr_addr = addr;
        #1;
        d = csr_rdata;
        csr_addr = CfgAddr;
    endtask

    // Disable the timer and acknowledge any leftover request in one access.
    task automatic cleanup();
        logic [31:0] rd;
        csr_access(OpWrite, CfgAddr, 32'h0, 1'b1, rd);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL reset_pend: got %b want 0", irq_pend);
        end
        checks++;
        if (irq_overrun !== 1'b0) begin
            errors++; $display("FAIL reset_overrun: got %b want 0", irq_overrun);
        end
        read_csr(CfgAddr, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_cfg: got %h want 00000000", rd);
        end
        read_csr(CntAddr, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL reset_count: got %h want 00000000", rd);
        end
        // Writing the count CSR must not touch the config.
        csr_access(OpWrite, CntAddr, 32'h0030_0003, 1'b0, rd);
        advance_to(6);
        read_csr(CfgAddr, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL count_write_ignored: got %h want 00000000", rd);
        end
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL count_write_no_irq: got %b want 0", irq_pend);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] rd;
        csr_access(OpWrite, CfgAddr, 32'h0030_0003, 1'b0, rd);
        advance_to(3);
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL per_e3_pend: got %b want 0", irq_pend);
        end
        advance_to(4);
        checks++;
        if (irq_pend !== 1'b1) begin
            errors++; $display("FAIL per_e4_pend: got %b want 1", irq_pend);
        end
        read_csr(CfgAddr, rd);
        checks++;
        if (rd !== 32'h0030_0003) begin
            errors++; $display("FAIL per_cfg_read: got %h want 00300003", rd);
        end
        advance_to(5);
        irq_ack = 1'b1;
        advance_to(6);
        irq_ack = 1'b0;
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL per_ack_clears: got %b want 0", irq_pend);
        end
        advance_to(7);
        read_csr(CntAddr, rd);
        checks++;
        if (rd !== 32'd3) begin
            errors++; $display("FAIL per_e7_count: got %h want 00000003", rd);
        end
        advance_to(8);
        checks++;
        if (irq_pend !== 1'b1) begin
            errors++; $display("FAIL per_e8_pend: got %b want 1", irq_pend);
        end
        read_csr(CntAddr, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL per_e8_count: got %h want 00000000", rd);
        end
        checks++;
        if (irq_overrun !== 1'b0) begin
            errors++; $display("FAIL per_no_overrun: got %b want 0", irq_overrun);
        end
        cleanup();
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL per_cleanup_pend: got %b want 0", irq_pend);
        end
    endtask

    task automatic test_prescaled();
        logic [31:0] rd;
        csr_access(OpWrite, CfgAddr, 32'h0032_0001, 1'b0, rd);
        advance_to(3);
        read_csr(CntAddr, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL pre_e3_count: got %h want 00000000", rd);
        end
        advance_to(4);
        read_csr(CntAddr, rd);
        checks++;
        if (rd !== 32'd1) begin
            errors++; $display("FAIL pre_e4_count: got %h want 00000001", rd);
        end
        advance_to(7);
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL pre_e7_pend: got %b want 0", irq_pend);
        end
        advance_to(8);
        checks++;
        if (irq_pend !== 1'b1) begin
            errors++; $display("FAIL pre_e8_pend: got %b want 1", irq_pend);
        end
        irq_ack = 1'b1;
        advance_to(9);
        irq_ack = 1'b0;
        advance_to(15);
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL pre_e15_pend: got %b want 0", irq_pend);
        end
        advance_to(16);
        checks++;
        if (irq_pend !== 1'b1) begin
            errors++; $display("FAIL pre_e16_pend: got %b want 1", irq_pend);
        end
        cleanup();
    endtask

    task automatic test_one_shot();
        logic [31:0] rd;
        logic        seen;
        csr_access(OpWrite, CfgAddr, 32'h0010_0002, 1'b0, rd);
        advance_to(2);
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL os_e2_pend: got %b want 0", irq_pend);
        end
        advance_to(3);
        checks++;
        if (irq_pend !== 1'b1) begin
            errors++; $display("FAIL os_e3_pend: got %b want 1", irq_pend);
        end
        read_csr(CfgAddr, rd);
        checks++;
        if (rd !== 32'h0000_0002) begin
            errors++; $display("FAIL os_cfg_en_cleared: got %h want 00000002", rd);
        end
        irq_ack = 1'b1;
        advance_to(4);
        irq_ack = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            seen = seen | irq_pend;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL os_no_rearm: got %b want 0", seen);
        end
        read_csr(CntAddr, rd);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL os_count_frozen: got %h want 00000000", rd);
        end
        cleanup();
    endtask

    task automatic test_overrun();
        logic [31:0] rd;
        csr_access(OpWrite, CfgAddr, 32'h0030_0001, 1'b0, rd);
        advance_to(2);
        checks++;
        if (irq_pend !== 1'b1) begin
            errors++; $display("FAIL ovr_e2_pend: got %b want 1", irq_pend);
        end
        advance_to(3);
        checks++;
        if (irq_overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_e3_flag: got %b want 0", irq_overrun);
        end
        advance_to(4);
        checks++;
        if (irq_overrun !== 1'b1) begin
            errors++; $display("FAIL ovr_e4_flag: got %b want 1", irq_overrun);
        end
        // Clear en; the read during the access cycle must still show the old image.
        csr_access(OpClear, CfgAddr, 32'h0010_0000, 1'b0, rd);
        checks++;
        if (rd !== 32'h0070_0001) begin
            errors++; $display("FAIL ovr_read_before_write: got %h want 00700001", rd);
        end
        read_csr(CfgAddr, rd);
        checks++;
        if (rd !== 32'h0020_0001) begin
            errors++; $display("FAIL ovr_clear_cfg: got %h want 00200001", rd);
        end
        checks++;
        if (irq_overrun !== 1'b0) begin
            errors++; $display("FAIL ovr_cleared: got %b want 0", irq_overrun);
        end
        checks++;
        if (irq_pend !== 1'b1) begin
            errors++; $display("FAIL ovr_pend_kept: got %b want 1", irq_pend);
        end
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL ovr_ack: got %b want 0", irq_pend);
        end
        // Ack coincident with an expiry edge.
        csr_access(OpWrite, CfgAddr, 32'h0030_0001, 1'b0, rd);
        advance_to(3);
        irq_ack = 1'b1;
        advance_to(4);
        irq_ack = 1'b0;
        checks++;
        if (irq_pend !== 1'b1) begin
            errors++; $display("FAIL sim_ack_pend: got %b want 1", irq_pend);
        end
        checks++;
        if (irq_overrun !== 1'b0) begin
            errors++; $display("FAIL sim_ack_overrun: got %b want 0", irq_overrun);
        end
        cleanup();
    endtask

    task automatic test_csr_wins();
        logic [31:0] rd;
        csr_access(OpWrite, CfgAddr, 32'h0030_0001, 1'b0, rd);
        advance_to(1);
        // Set-op with a zero operand lands on the would-be expiry edge.
        csr_access(OpSet, CfgAddr, 32'h0, 1'b0, rd);
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL win_no_expiry: got %b want 0", irq_pend);
        end
        advance_to(1);
        checks++;
        if (irq_pend !== 1'b0) begin
            errors++; $display("FAIL win_e1_pend: got %b want 0", irq_pend);
        end
        advance_to(2);
        checks++;
        if (irq_pend !== 1'b1) begin
            errors++; $display("FAIL win_e2_pend: got %b want 1", irq_pend);
        end
        cleanup();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        seen;
        csr_access(OpWrite, CfgAddr, 32'h0030_0009, 1'b0, rd);
        advance_to(5);
        read_csr(CntAddr, rd);
        checks++;
        if (rd !== 32'd5) begin
            errors++; $display("FAIL mid_count_before: got %h want 00000005", rd);
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        read_csr(CfgAddr, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL mid_cfg_cleared: got %h want 00000000", rd);
        end
        read_csr(CntAddr, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL mid_count_cleared: got %h want 00000000", rd);
        end
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            seen = seen | irq_pend;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL mid_no_irq_after: got %b want 0", seen);
        end
        read_csr(CntAddr, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++; $display("FAIL mid_stays_idle: got %h want 00000000", rd);
        end
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        cyc        = 0;
        reset      = 1'b0;
        csr_enable = 1'b0;
        csr_addr   = CfgAddr;
        csr_op     = 2'b00;
        csr_wdata  = '0;
        irq_ack    = 1'b0;

        test_reset();
        test_periodic();
        test_prescaled();
        test_one_shot();
        test_overrun();
        test_csr_wins();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
